// File: rtl/mulu_x2y2_acc.sv
// Running-sum accumulator for the 2x2 multiplier product, with a snapshot that is
// streamed out least significant nibble first over a valid/ready handshake.
module mulu_x2y2_acc #(
    parameter int P_WIDTH   = 4,
    parameter int ACC_WIDTH = 8,
    parameter bit SATURATE  = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [P_WIDTH-1:0] p_in,
    input  logic               p_valid,
    input  logic               acc_clr,
    input  logic               dump,
    output logic [3:0]         out_nib,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy,
    output logic               ovf,
    output logic [3:0]         cnt
);

    localparam int NBEATS = ACC_WIDTH / 4;
    localparam int IDX_W  = $clog2(NBEATS);

    typedef enum logic {
        ST_ACC,
        ST_DUMP
    } state_t;

    state_t                 r_state;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [ACC_WIDTH-1:0]   r_snap;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_ovf;
    logic [3:0]             r_cnt;
    logic [3:0]             r_nib;
    logic                   r_valid;
    logic                   r_last;

    logic [ACC_WIDTH:0]     w_sum;
    logic [ACC_WIDTH-1:0]   w_acc_nxt;
    logic                   w_ovf_nxt;
    logic [3:0]             w_cnt_nxt;
    logic [IDX_W-1:0]       w_idx_inc;
    logic [3:0]             w_nib_next;

    assign w_sum      = {1'b0, r_acc} + (ACC_WIDTH+1)'(p_in);
    assign w_idx_inc  = r_idx + IDX_W'(1);
    assign w_nib_next = r_snap[{w_idx_inc, 2'b00} +: 4];

    // Next live-accumulator value; the snapshot captures this so a same-cycle
    // sample or clear is reflected in the dumped value.
    always_comb begin
        w_acc_nxt = r_acc;
        w_ovf_nxt = r_ovf;
        w_cnt_nxt = r_cnt;
        if (acc_clr) begin
            w_acc_nxt = '0;
            w_ovf_nxt = 1'b0;
            w_cnt_nxt = 4'd0;
        end else if (p_valid) begin
            if (w_sum[ACC_WIDTH]) begin
                w_ovf_nxt = 1'b1;
                w_acc_nxt = SATURATE ? '1 : w_sum[ACC_WIDTH-1:0];
            end else begin
                w_acc_nxt = w_sum[ACC_WIDTH-1:0];
            end
            if (r_cnt != 4'hF) w_cnt_nxt = r_cnt + 4'd1;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_ACC;
            r_acc   <= '0;
            r_snap  <= '0;
            r_idx   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= 4'd0;
            r_nib   <= 4'd0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_acc <= w_acc_nxt;
            r_ovf <= w_ovf_nxt;
            r_cnt <= w_cnt_nxt;
            case (r_state)
                ST_ACC: begin
                    if (dump) begin
                        r_snap  <= w_acc_nxt;
                        r_idx   <= '0;
                        r_nib   <= w_acc_nxt[3:0];
                        r_valid <= 1'b1;
                        r_last  <= 1'b0;
                        r_state <= ST_DUMP;
                    end
                end
                ST_DUMP: begin
                    // Output regs only advance on a handshake, so a stalled beat holds.
                    if (out_ready) begin
                        if (r_last) begin
                            r_nib   <= 4'd0;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_state <= ST_ACC;
                        end else begin
                            r_idx  <= w_idx_inc;
                            r_nib  <= w_nib_next;
                            r_last <= (w_idx_inc == IDX_W'(NBEATS - 1));
                        end
                    end
                end
            endcase
        end
    end

    assign out_nib   = r_nib;
    assign out_valid = r_valid;
    assign out_last  = r_last;
    assign busy      = (r_state == ST_DUMP);
    assign ovf       = r_ovf;
    assign cnt       = r_cnt;

endmodule

// File: tb/tb_mulu_x2y2_acc.sv
// Self-checking bench: a saturating and a wrapping instance share stimulus and are
// compared every cycle against a sum-and-shift model, plus literal expectations.
module tb_mulu_x2y2_acc;

    localparam int NB   = 2;
    localparam int MAXV = 255;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] p_in;
    logic       p_valid, acc_clr, dump, out_ready;

    logic [3:0] d_nib   [2];
    logic       d_valid [2];
    logic       d_last  [2];
    logic       d_busy  [2];
    logic       d_ovf   [2];
    logic [3:0] d_cnt   [2];

    int n_checks = 0;
    int n_errors = 0;

    // Model: live sum per instance, plus the not-yet-sent part of the snapshot.
    int m_acc  [2];
    int m_ovf  [2];
    int m_cnt  [2];
    int m_rest [2];
    int m_left [2];

    always #5 clk = ~clk;

    mulu_x2y2_acc #(.P_WIDTH(4), .ACC_WIDTH(8), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(reset), .p_in(p_in), .p_valid(p_valid), .acc_clr(acc_clr),
        .dump(dump), .out_nib(d_nib[0]), .out_valid(d_valid[0]), .out_ready(out_ready),
        .out_last(d_last[0]), .busy(d_busy[0]), .ovf(d_ovf[0]), .cnt(d_cnt[0])
    );

    mulu_x2y2_acc #(.P_WIDTH(4), .ACC_WIDTH(8), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .p_in(p_in), .p_valid(p_valid), .acc_clr(acc_clr),
        .dump(dump), .out_nib(d_nib[1]), .out_valid(d_valid[1]), .out_ready(out_ready),
        .out_last(d_last[1]), .busy(d_busy[1]), .ovf(d_ovf[1]), .cnt(d_cnt[1])
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = 0; m_ovf[k] = 0; m_cnt[k] = 0; m_rest[k] = 0; m_left[k] = 0;
        end
    endtask

    task automatic compare();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("out_valid[%0d]", k), int'(d_valid[k]), int'(m_left[k] > 0));
            check($sformatf("busy[%0d]", k),      int'(d_busy[k]),  int'(m_left[k] > 0));
            check($sformatf("out_nib[%0d]", k),   int'(d_nib[k]),   (m_left[k] > 0) ? (m_rest[k] & 15) : 0);
            check($sformatf("out_last[%0d]", k),  int'(d_last[k]),  int'(m_left[k] == 1));
            check($sformatf("ovf[%0d]", k),       int'(d_ovf[k]),   m_ovf[k]);
            check($sformatf("cnt[%0d]", k),       int'(d_cnt[k]),   m_cnt[k]);
        end
    endtask

    task automatic model_step();
        int nxt, s;
        for (int k = 0; k < 2; k++) begin
            nxt = m_acc[k];
            if (acc_clr) begin
                nxt = 0; m_ovf[k] = 0; m_cnt[k] = 0;
            end else if (p_valid) begin
                s = m_acc[k] + int'(p_in);
                if (s > MAXV) begin
                    m_ovf[k] = 1;
                    nxt = (k == 0) ? MAXV : s - (MAXV + 1);
                end else begin
                    nxt = s;
                end
                if (m_cnt[k] < 15) m_cnt[k]++;
            end
            if (m_left[k] == 0) begin
                if (dump) begin
                    m_rest[k] = nxt;
                    m_left[k] = NB;
                end
            end else if (out_ready) begin
                m_rest[k] = m_rest[k] >> 4;
                m_left[k]--;
            end
            m_acc[k] = nxt;
        end
    endtask

    // One clock cycle: drive, compare, advance model, move to the next falling edge.
    task automatic cyc(input logic pv, input logic [3:0] p, input logic clr,
                       input logic dmp, input logic rdy);
        p_valid = pv; p_in = p; acc_clr = clr; dump = dmp; out_ready = rdy;
        compare();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic lit_beat(input string tag, input int k, input int nib, input int last);
        check($sformatf("%s valid[%0d]", tag, k), int'(d_valid[k]), 1);
        check($sformatf("%s nib[%0d]", tag, k),   int'(d_nib[k]),   nib);
        check($sformatf("%s last[%0d]", tag, k),  int'(d_last[k]),  last);
    endtask

    // Dump on a cycle with the given sample/clear inputs, then stream with ready high.
    task automatic dump_expect(input string tag, input logic pv, input logic [3:0] p,
                               input logic clr, input int s0, input int s1,
                               input int w0, input int w1);
        cyc(pv, p, clr, 1'b1, 1'b1);
        lit_beat({tag, " b0"}, 0, s0, 0);
        lit_beat({tag, " b0"}, 1, w0, 0);
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        lit_beat({tag, " b1"}, 0, s1, 1);
        lit_beat({tag, " b1"}, 1, w1, 1);
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        check({tag, " idle valid"}, int'(d_valid[0] | d_valid[1]), 0);
    endtask

    initial begin
        reset = 1'b0;
        p_in = 4'd0; p_valid = 1'b0; acc_clr = 1'b0; dump = 1'b0; out_ready = 1'b0;
        model_reset();
        #1;
        compare();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Basic sum: 3 x 9 = 0x1B.
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'd9, 1'b0, 1'b0, 1'b1);
        check("basic cnt", int'(d_cnt[0]), 3);
        check("basic ovf", int'(d_ovf[0]), 0);
        dump_expect("basic", 1'b0, 4'd0, 1'b0, 'hB, 'h1, 'hB, 'h1);
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);

        // Overflow: 30 x 9 = 270 -> clamp 0xFF / wrap 0x0E.
        for (int i = 0; i < 30; i++) cyc(1'b1, 4'd9, 1'b0, 1'b0, 1'b1);
        check("sat ovf", int'(d_ovf[0]), 1);
        check("sat cnt", int'(d_cnt[0]), 15);
        check("wrap ovf30", int'(d_ovf[1]), 1);
        dump_expect("sat", 1'b0, 4'd0, 1'b0, 'hF, 'hF, 'hE, 'h0);
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        check("clr ovf", int'(d_ovf[0]), 0);
        check("clr cnt", int'(d_cnt[0]), 0);
        dump_expect("clr", 1'b0, 4'd0, 1'b0, 0, 0, 0, 0);

        // 0xFC + 6: wrap -> 0x02, clamp -> 0xFF; both flag overflow.
        for (int i = 0; i < 28; i++) cyc(1'b1, 4'd9, 1'b0, 1'b0, 1'b1);
        check("fc ovf", int'(d_ovf[1]), 0);
        cyc(1'b1, 4'd6, 1'b0, 1'b0, 1'b1);
        check("wrap ovf", int'(d_ovf[1]), 1);
        check("sat ovf2", int'(d_ovf[0]), 1);
        dump_expect("wrap", 1'b0, 4'd0, 1'b0, 'hF, 'hF, 'h2, 'h0);
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);

        // Backpressure on 0x5A with samples arriving mid-stream.
        for (int i = 0; i < 10; i++) cyc(1'b1, 4'd9, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            lit_beat("stall", 0, 'hA, 0);
            cyc(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        end
        lit_beat("stall end", 1, 'hA, 0);
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        lit_beat("bp b1", 0, 'h5, 1);
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        check("bp idle", int'(d_valid[0]), 0);
        dump_expect("bp next", 1'b0, 4'd0, 1'b0, 'hE, 'h5, 'hE, 'h5);
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);

        // Same-cycle events.
        cyc(1'b1, 4'd8, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 4'd8, 1'b0, 1'b0, 1'b1);
        dump_expect("dump+pv", 1'b1, 4'd4, 1'b0, 'h4, 'h1, 'h4, 'h1);
        dump_expect("clr+pv+dump", 1'b1, 4'd5, 1'b1, 0, 0, 0, 0);
        cyc(1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        lit_beat("lastdump b0", 0, 'h3, 0);
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        lit_beat("lastdump b1", 0, 'h0, 1);
        cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        check("lastdump ignored", int'(d_valid[0]), 0);
        check("lastdump busy", int'(d_busy[1]), 0);
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        check("lastdump still idle", int'(d_valid[1]), 0);

        // Reset on the first beat of a stream.
        cyc(1'b1, 4'd7, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        lit_beat("pre-rst", 0, 'hA, 0);
        reset = 1'b0;
        #1;
        model_reset();
        check("rst valid", int'(d_valid[0]), 0);
        check("rst nib", int'(d_nib[0]), 0);
        check("rst busy", int'(d_busy[0]), 0);
        check("rst cnt", int'(d_cnt[1]), 0);
        compare();
        @(negedge clk);
        reset = 1'b1;
        dump_expect("post-rst", 1'b0, 4'd0, 1'b0, 0, 0, 0, 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 3) != 0));
        end
        compare();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mulu_x2y2_acc.md
Name: mulu_x2y2_acc

Overview:
- Sequential stage directly downstream of the 2x2 unsigned multiplier. Consumes its 4-bit product p and accumulates a running sum of products.
- On request, snapshots the sum and streams it out as 4-bit nibbles over a valid/ready handshake, so a wide result fits the narrow output pin budget.
- Accumulation continues while a previous snapshot is still being streamed.

Parameters:
- P_WIDTH, 4, width of the product input; matches the multiplier product width.
- ACC_WIDTH, 8, accumulator width; must be a multiple of 4 and at least 8.
- SATURATE, 1, 1 = clamp at all-ones on overflow; 0 = wrap modulo 2^ACC_WIDTH.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- p_in  input  P_WIDTH  product from the multiplier.
- p_valid  input  1  p_in is sampled this cycle.
- acc_clr  input  1  synchronous clear of the live accumulator, overflow flag and sample count.
- dump  input  1  request a snapshot and stream-out.
- out_nib  output  4  current output nibble; 0 when out_valid=0.
- out_valid  output  1  out_nib holds a valid beat.
- out_ready  input  1  consumer accepts the beat this cycle.
- out_last  output  1  current beat is the final (most significant) nibble.
- busy  output  1  a stream-out is in progress; dump is ignored.
- ovf  output  1  sticky overflow flag of the live accumulator.
- cnt  output  4  number of accepted samples since the last clear; saturates at 15.

Behaviour:
- Reset: forces these values while reset=0, independent of clk:
  - acc, snap, ovf, cnt, beat index = 0; FSM = ACC.
  - out_valid, out_last, busy = 0; out_nib = 0.
- Accumulate (in any FSM state):
  - When p_valid=1 and acc_clr=0: acc <= acc + zero-extended p_in; cnt <= min(cnt+1, 15).
  - On carry-out with SATURATE=1: acc <= all-ones and ovf <= 1.
  - On carry-out with SATURATE=0: acc <= sum mod 2^ACC_WIDTH and ovf <= 1.
  - ovf stays set until acc_clr or reset.
- acc_clr: acc, ovf and cnt <= 0. It has priority over p_valid in the same cycle, and that sample is dropped. It never touches snap or an active stream.
- FSM has two states, ACC and DUMP.
- ACC:
  - busy=0, out_valid=0.
  - dump=1 -> snap <= next-cycle acc value, i.e. it includes a same-cycle p_valid sample and reflects a same-cycle acc_clr (snap=0). Beat index <= 0; go to DUMP.
  - Latency: dump in cycle N gives out_valid=1 in cycle N+1.
- DUMP:
  - busy=1, out_valid=1, out_nib = snap[4*i+3:4*i] where i is the beat index; least significant nibble first.
  - out_last=1 only when i = ACC_WIDTH/4-1.
  - out_ready=0 -> hold out_nib, out_last and i stable; no beat may be skipped or repeated.
  - out_ready=1 and not last -> i <= i+1.
  - out_ready=1 and last -> go to ACC. out_valid falls the next cycle. A dump in that same handshake cycle is ignored; dump is only honoured in ACC.
  - dump while in DUMP is ignored; no queueing.
- Throughput: with out_ready held high, a stream takes exactly ACC_WIDTH/4 cycles. The earliest next out_valid is 2 cycles after the last beat is accepted (one ACC cycle for dump, then the new stream).
- Reset mid-stream: the stream is aborted immediately, all outputs return to their reset values, and no partial resume occurs.
- Outputs are registered or decoded only from state registers; there is no combinational path from out_ready to out_valid or out_nib.

Test Plan:
- Reset release, then p_in=9 with p_valid for 3 cycles, then dump, out_ready=1 -> beats 0xB, then 0x1 with out_last=1; cnt=3, ovf=0.
- SATURATE=1: 30 samples of p_in=9 -> acc clamps at 0xFF, ovf=1, cnt=15. Dump streams 0xF, 0xF. acc_clr then clears ovf and cnt, and acc reads 0 on the next dump.
- SATURATE=0: acc=0xFC plus p_in=6 -> acc=0x02, ovf=1.
- Backpressure: dump with acc=0x5A, out_ready=0 for 4 cycles -> out_nib holds 0xA and out_last=0 throughout. out_ready=1 -> 0xA then 0x5. Samples fed during the stream are excluded from that stream but present in the next dump.
- Same-cycle events:
  - dump together with p_valid p_in=4 on acc=0x10 -> stream 0x4, 0x1.
  - acc_clr, p_valid and dump together -> stream 0x0, 0x0.
  - dump on the final handshake cycle -> ignored; out_valid low for one cycle.
- Assert reset low on the first beat of a stream -> out_valid, out_nib, busy and acc read 0 without a clock edge. After release, a dump streams 0x0, 0x0.
